// File: rtl/alarm_key_entry_pkg.sv
// rtl/alarm_key_entry_pkg.sv - shared clock package: state encoding and BCD limits
package alarm_key_entry_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY      = 2'd1,
    SHOW_ALARM = 2'd2
  } state_t;

  localparam logic [3:0] MAX_MS_HR  = 4'd2;
  localparam logic [7:0] MAX_HR     = 8'd23;
  localparam logic [3:0] MAX_MS_MIN = 4'd5;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  function automatic logic is_digit(input logic [3:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/alarm_key_entry_bcd_time_check.sv
// rtl/alarm_key_entry_bcd_time_check.sv - combinational HH:MM BCD range check
module bcd_time_check
  import alarm_key_entry_pkg::*;
(
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  output logic       valid
);

  logic [7:0] hour;

  // 8 bits so that even non-BCD codes (15*10+15) cannot wrap into range
  always_comb begin
    hour  = ({4'd0, ms_hr} * 8'd10) + {4'd0, ls_hr};
    valid = is_digit(ms_hr) && is_digit(ls_hr) && is_digit(ms_min) && is_digit(ls_min)
            && (ms_hr <= MAX_MS_HR) && (hour <= MAX_HR) && (ms_min <= MAX_MS_MIN);
  end

endmodule

// File: rtl/alarm_key_entry.sv
// rtl/alarm_key_entry.sv - keypad HH:MM entry buffer with load pulses and idle timeout
module alarm_key_entry
  import alarm_key_entry_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       load_time_key,
  input  logic       load_alarm_key,
  input  logic       show_alarm_key,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error
);

  state_t     state, state_nxt;
  logic [3:0] timer, timer_nxt;
  logic [3:0] ms_hr_nxt, ls_hr_nxt, ms_min_nxt, ls_min_nxt;
  logic       load_c_nxt, load_a_nxt, error_nxt, show_new_nxt, show_a_nxt;
  logic       digit_ok, timeout_hit, time_ok;

  bcd_time_check u_check (
    .ms_hr  (new_current_time_ms_hr),
    .ls_hr  (new_current_time_ls_hr),
    .ms_min (new_current_time_ms_min),
    .ls_min (new_current_time_ls_min),
    .valid  (time_ok)
  );

  assign digit_ok    = key_valid && is_digit(key);
  assign timeout_hit = one_second && (timer == 4'(TIMEOUT_S - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (digit_ok)            state_nxt = ENTRY;
        else if (show_alarm_key) state_nxt = SHOW_ALARM;
      end
      SHOW_ALARM: begin
        if (digit_ok)             state_nxt = ENTRY;
        else if (!show_alarm_key) state_nxt = IDLE;
      end
      ENTRY: begin
        if (load_time_key || load_alarm_key) state_nxt = IDLE;
        else if (digit_ok)                   state_nxt = ENTRY;
        else if (timeout_hit)                state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ms_hr_nxt  = new_current_time_ms_hr;
    ls_hr_nxt  = new_current_time_ls_hr;
    ms_min_nxt = new_current_time_ms_min;
    ls_min_nxt = new_current_time_ls_min;
    timer_nxt  = 4'd0;
    load_c_nxt = 1'b0;
    load_a_nxt = 1'b0;
    error_nxt  = 1'b0;
    case (state)
      ENTRY: begin
        if (load_time_key) begin
          load_c_nxt = time_ok;
          error_nxt  = !time_ok;
        end else if (load_alarm_key) begin
          load_a_nxt = time_ok;
          error_nxt  = !time_ok;
        end else if (digit_ok) begin
          ms_hr_nxt  = new_current_time_ls_hr;
          ls_hr_nxt  = new_current_time_ms_min;
          ms_min_nxt = new_current_time_ls_min;
          ls_min_nxt = key;
        end else if (timeout_hit) begin
          {ms_hr_nxt, ls_hr_nxt, ms_min_nxt, ls_min_nxt} = 16'h0000;
        end else begin
          timer_nxt = timer + {3'd0, one_second};
        end
      end
      default: begin
        if (digit_ok) {ms_hr_nxt, ls_hr_nxt, ms_min_nxt, ls_min_nxt} = {12'h000, key};
      end
    endcase
    show_new_nxt = (state_nxt == ENTRY);
    show_a_nxt   = (state_nxt == SHOW_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_current_time_ms_hr  <= 4'd0;
      new_current_time_ls_hr  <= 4'd0;
      new_current_time_ms_min <= 4'd0;
      new_current_time_ls_min <= 4'd0;
      timer                   <= 4'd0;
      load_new_c              <= 1'b0;
      load_new_a              <= 1'b0;
      entry_error             <= 1'b0;
      show_new_time           <= 1'b0;
      show_a                  <= 1'b0;
    end else begin
      new_current_time_ms_hr  <= ms_hr_nxt;
      new_current_time_ls_hr  <= ls_hr_nxt;
      new_current_time_ms_min <= ms_min_nxt;
      new_current_time_ls_min <= ls_min_nxt;
      timer                   <= timer_nxt;
      load_new_c              <= load_c_nxt;
      load_new_a              <= load_a_nxt;
      entry_error             <= error_nxt;
      show_new_time           <= show_new_nxt;
      show_a                  <= show_a_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_key_entry.sv
// tb/tb_alarm_key_entry.sv - directed self-checking bench for alarm_key_entry
module tb_alarm_key_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       load_time_key = 1'b0;
  logic       load_alarm_key = 1'b0;
  logic       show_alarm_key = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_new_time, show_a, entry_error;

  int checks = 0;
  int errors = 0;

  alarm_key_entry #(.TIMEOUT_S(10)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_second              (one_second),
    .key_valid               (key_valid),
    .key                     (key),
    .load_time_key           (load_time_key),
    .load_alarm_key          (load_alarm_key),
    .show_alarm_key          (show_alarm_key),
    .new_current_time_ms_hr  (ms_hr),
    .new_current_time_ls_hr  (ls_hr),
    .new_current_time_ms_min (ms_min),
    .new_current_time_ls_min (ls_min),
    .load_new_c              (load_new_c),
    .load_new_a              (load_new_a),
    .show_new_time           (show_new_time),
    .show_a                  (show_a),
    .entry_error             (entry_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] buffer();
    return {ms_hr, ls_hr, ms_min, ls_min};
  endfunction

  function automatic logic [15:0] flags();
    return {11'd0, load_new_c, load_new_a, show_new_time, show_a, entry_error};
  endfunction

  // flags layout: {load_new_c, load_new_a, show_new_time, show_a, entry_error}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] digits);
    for (int i = 3; i >= 0; i--) press(4'((digits >> (i * 4)) & 16'hF));
  endtask

  task automatic tick();
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    check("reset_buf", buffer(), 16'h0000);
    check("reset_flags", flags(), 16'h0000);
    reset = 1'b0;
    step();
    check("idle_flags", flags(), 16'h0000);

    // valid time commit
    press(4'd1);
    check("first_digit_buf", buffer(), 16'h0001);
    check("first_digit_flags", flags(), 16'h0004);
    press(4'd2); press(4'd3); press(4'd4);
    check("entry_1234", buffer(), 16'h1234);
    load_time_key = 1'b1; step(); load_time_key = 1'b0;
    check("load_c_pulse", flags(), 16'h0010);
    check("load_c_buf", buffer(), 16'h1234);
    step();
    check("load_c_one_cycle", flags(), 16'h0000);
    check("buf_held", buffer(), 16'h1234);

    // hour 24 rejected
    enter4(16'h2400);
    load_time_key = 1'b1; step(); load_time_key = 1'b0;
    check("err_2400", flags(), 16'h0001);
    check("err_buf", buffer(), 16'h2400);
    step();
    check("err_one_cycle", flags(), 16'h0000);

    // alarm commit
    enter4(16'h0730);
    load_alarm_key = 1'b1; step(); load_alarm_key = 1'b0;
    check("load_a_pulse", flags(), 16'h0008);
    check("load_a_buf", buffer(), 16'h0730);

    // minutes tens 6 rejected on alarm path
    enter4(16'h1960);
    load_alarm_key = 1'b1; step(); load_alarm_key = 1'b0;
    check("err_1960", flags(), 16'h0001);

    // 23:59 is the upper bound
    enter4(16'h2359);
    load_time_key = 1'b1; step(); load_time_key = 1'b0;
    check("load_2359", flags(), 16'h0010);

    // idle timeout
    press(4'd5);
    check("timeout_start", buffer(), 16'h0005);
    for (int i = 0; i < 9; i++) tick();
    check("after_9_ticks", flags(), 16'h0004);
    check("after_9_buf", buffer(), 16'h0005);
    one_second = 1'b1; step(); one_second = 1'b0;
    check("timeout_flags", flags(), 16'h0000);
    check("timeout_buf", buffer(), 16'h0000);

    // digit and tick together: digit wins, timer restarts
    press(4'd6);
    for (int i = 0; i < 9; i++) tick();
    one_second = 1'b1; key_valid = 1'b1; key = 4'd7; step();
    one_second = 1'b0; key_valid = 1'b0;
    check("tick_digit_buf", buffer(), 16'h0067);
    check("tick_digit_open", flags(), 16'h0004);
    tick();
    check("timer_restarted", flags(), 16'h0004);
    load_alarm_key = 1'b1; step(); load_alarm_key = 1'b0;

    // non-digit key ignored
    enter4(16'h1540);
    press(4'hA);
    check("key_a_ignored", buffer(), 16'h1540);
    check("key_a_open", flags(), 16'h0004);
    load_time_key = 1'b1; step(); load_time_key = 1'b0;
    check("load_1540", flags(), 16'h0010);

    // load beats a same-cycle digit
    press(4'd3);
    load_time_key = 1'b1; key_valid = 1'b1; key = 4'd7; step();
    load_time_key = 1'b0; key_valid = 1'b0;
    check("load_over_digit_flags", flags(), 16'h0010);
    check("load_over_digit_buf", buffer(), 16'h0003);

    // show alarm, then a digit takes priority
    show_alarm_key = 1'b1; step();
    check("show_alarm", flags(), 16'h0002);
    load_time_key = 1'b1; step(); load_time_key = 1'b0;
    check("show_alarm_load_ignored", flags(), 16'h0002);
    press(4'd8);
    check("show_alarm_digit", flags(), 16'h0004);
    check("show_alarm_digit_buf", buffer(), 16'h0008);
    show_alarm_key = 1'b0;

    // reset mid-entry with a load pending
    press(4'd1);
    reset = 1'b1; load_time_key = 1'b1; step();
    load_time_key = 1'b0;
    check("reset_mid_flags", flags(), 16'h0000);
    check("reset_mid_buf", buffer(), 16'h0000);
    reset = 1'b0;
    step();
    check("post_reset_idle", flags(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
